// File: rtl/flip_inject_pkg.sv
// Shared types and constants for the flip-flop fault-injection controller.
// Holds the FSM state encoding, the select slot width and the err_o status codes.
package flip_inject_pkg;

    localparam int SLOT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_INJECT,
        ST_DONE
    } state_e;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_TARGET = 2'd1;
    localparam logic [1:0] ERR_ABORT  = 2'd2;

    // An all-zero mask would inject nothing, so it is promoted to a single-bit flip.
    function automatic logic [2:0] norm_mask(input logic [2:0] m);
        return (m == 3'b000) ? 3'b001 : m;
    endfunction

endpackage

// File: rtl/inject_down_cnt.sv
// Loadable down-counter shared by the delay and injection-length phases.
// A load wins over a decrement; the counter stops at zero.
module inject_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/flip_inject_ctrl.sv
// Fault-injection controller: accepts one request at a time and, after a delay,
// drives a bit-flip mask onto one flip-flop select slot for a programmed number of cycles.
module flip_inject_ctrl
    import flip_inject_pkg::*;
#(
    parameter int NUM_SEL = 10,
    parameter int DLY_W   = 16
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                cfg_valid,
    output logic                                                cfg_ready,
    input  logic [((NUM_SEL > 1) ? $clog2(NUM_SEL) : 1)-1:0]    cfg_target,
    input  logic [2:0]                                          cfg_mask,
    input  logic [DLY_W-1:0]                                    cfg_delay,
    input  logic [3:0]                                          cfg_len,
    input  logic                                                abort,
    output logic [SLOT_W*NUM_SEL-1:0]                           sel_o,
    output logic                                                done_o,
    output logic [1:0]                                          err_o,
    output logic [15:0]                                         inj_cnt_o
);

    localparam int TGT_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
    localparam int CNT_W = (DLY_W > 4) ? DLY_W : 4;

    state_e                     r_state;
    logic [TGT_W-1:0]           r_tgt;
    logic [2:0]                 r_mask;
    logic [3:0]                 r_len;
    logic [SLOT_W*NUM_SEL-1:0]  r_sel;
    logic                       r_done;
    logic [1:0]                 r_err;
    logic [15:0]                r_inj_cnt;

    logic                       w_accept;
    logic                       w_tgt_ok;
    logic                       w_cnt_zero;
    logic                       w_load;
    logic                       w_dec;
    logic [CNT_W-1:0]           w_load_val;
    logic [TGT_W-1:0]           w_pat_tgt;
    logic [2:0]                 w_pat_mask;
    logic [SLOT_W*NUM_SEL-1:0]  w_pattern;

    // The counter holds "cycles remaining minus one", so a zero length still gives one cycle.
    function automatic logic [CNT_W-1:0] len_load(input logic [3:0] l);
        return (l == 4'd0) ? '0 : CNT_W'(l - 4'd1);
    endfunction

    assign w_accept = cfg_valid && (r_state == ST_IDLE);
    assign w_tgt_ok = (32'(cfg_target) < NUM_SEL);

    assign w_pat_tgt  = (r_state == ST_IDLE) ? cfg_target : r_tgt;
    assign w_pat_mask = (r_state == ST_IDLE) ? norm_mask(cfg_mask) : r_mask;

    always_comb begin
        w_pattern = '0;
        for (int k = 0; k < NUM_SEL; k++) begin
            if (32'(w_pat_tgt) == k) begin
                w_pattern[k*SLOT_W +: SLOT_W] = w_pat_mask;
            end
        end
    end

    // The counter is loaded with the delay on accept, then reloaded with the length
    // when injection starts; delay 0 skips straight to the length.
    always_comb begin
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_tgt_ok) begin
                    w_load     = 1'b1;
                    w_load_val = (cfg_delay == '0) ? len_load(cfg_len)
                                                   : CNT_W'(cfg_delay - 1'b1);
                end
            end
            ST_WAIT: begin
                if (!abort) begin
                    if (w_cnt_zero) begin
                        w_load     = 1'b1;
                        w_load_val = len_load(r_len);
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            ST_INJECT: begin
                if (!abort && !w_cnt_zero) begin
                    w_dec = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    inject_down_cnt #(
        .W (CNT_W)
    ) u_down_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tgt     <= '0;
            r_mask    <= 3'b000;
            r_len     <= 4'd0;
            r_sel     <= '0;
            r_done    <= 1'b0;
            r_err     <= ERR_OK;
            r_inj_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= ERR_OK;
                    if (w_accept) begin
                        r_tgt  <= cfg_target;
                        r_mask <= norm_mask(cfg_mask);
                        r_len  <= cfg_len;
                        if (!w_tgt_ok) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= ERR_TARGET;
                        end else if (cfg_delay == '0) begin
                            r_state <= ST_INJECT;
                            r_sel   <= w_pattern;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= ERR_ABORT;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_INJECT;
                        r_sel   <= w_pattern;
                    end
                end
                // Abort outranks the final injection cycle: no success is counted.
                ST_INJECT: begin
                    if (abort) begin
                        r_state <= ST_DONE;
                        r_sel   <= '0;
                        r_done  <= 1'b1;
                        r_err   <= ERR_ABORT;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_DONE;
                        r_sel   <= '0;
                        r_done  <= 1'b1;
                        r_err   <= ERR_OK;
                        if (r_inj_cnt != 16'hFFFF) begin
                            r_inj_cnt <= r_inj_cnt + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= ERR_OK;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (r_state == ST_IDLE);
    assign sel_o     = r_sel;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign inj_cnt_o = r_inj_cnt;

endmodule

// File: doc/flip_inject_ctrl.md
FLIP_INJECT_CTRL -- requirements
Module: flip_inject_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SEL, default 10, number of flip-flop select slots driven.
REQ-002 The block SHALL have parameter DLY_W, default 16, width of the injection delay counter.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port cfg_valid, input, 1, injection request valid.
REQ-006 The block SHALL have port cfg_ready, output, 1, request may be accepted this cycle.
REQ-007 The block SHALL have port cfg_target, input, $clog2(NUM_SEL), slot index to corrupt.
REQ-008 The block SHALL have port cfg_mask, input, 3, bit-flip mask applied to the target slot.
REQ-009 The block SHALL have port cfg_delay, input, DLY_W, cycles to wait before injecting.
REQ-010 The block SHALL have port cfg_len, input, 4, number of consecutive injection cycles.
REQ-011 The block SHALL have port abort, input, 1, cancel pending or active injection.
REQ-012 The block SHALL have port sel_o, output, 3*NUM_SEL, flattened XOR selects; slot k is bits [3k+2:3k], 1-bit selects use bit 3k only.
REQ-013 The block SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-014 The block SHALL have port err_o, output, 2, status qualified by done_o: 0 ok, 1 bad target, 2 aborted.
REQ-015 The block SHALL have port inj_cnt_o, output, 16, count of successfully completed injections.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, INJECT, DONE; cfg_ready = 1 only in IDLE.
REQ-017 Request SHALL be accepted when cfg_valid && cfg_ready; target, mask, delay, len latched on that edge.
REQ-018 Accept with cfg_target >= NUM_SEL SHALL go directly to DONE with err_o=1 and no sel_o activity.
REQ-019 Mask 3'b000 SHALL be treated as 3'b001; cfg_len 0 SHALL be treated as 1.
REQ-020 Accept at edge T SHALL place sel_o slot target = mask for cycles T+1+delay through T+delay+len; delay 0 injects in the cycle after accept.
REQ-021 sel_o SHALL be registered; all non-target slots and all slots outside INJECT SHALL be zero.
REQ-022 After the last injection cycle the FSM SHALL enter DONE, drive done_o=1, err_o=0 for one cycle, then IDLE.
REQ-023 abort in WAIT or INJECT SHALL zero sel_o from the next cycle and enter DONE with err_o=2; abort in IDLE or DONE SHALL be ignored.
REQ-024 abort in the same cycle as the final injection cycle SHALL take priority (err_o=2, no count increment).
REQ-025 inj_cnt_o SHALL increment once per err_o=0 completion and saturate at 16'hFFFF.
REQ-026 cfg_valid while not ready SHALL be ignored; requester holds it until accepted.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, sel_o=0, done_o=0, err_o=0, inj_cnt_o=0, counters 0, regardless of state, including mid-INJECT.
REQ-028 First accept after rst_n deasserts SHALL be possible on the first rising edge with rst_n high.

Structure
REQ-029 Package flip_inject_pkg SHALL hold the FSM state enum, SLOT_W=3, and err_o code constants.
REQ-030 Delay/length countdown SHALL be one sub-module, inject_down_cnt (load, decrement, zero flag).

Verification
REQ-031 target=3, mask=3'b101, delay=0, len=1 accepted at cycle 10 -> sel_o[11:9]=3'b101 in cycle 11 only, done_o cycle 12, inj_cnt_o=1.
REQ-032 target=0, delay=5, len=3 accepted cycle 0 -> sel_o[2:0]=3'b001 cycles 6-8, zero elsewhere, cfg_ready low cycles 1-9.
REQ-033 target=12 (NUM_SEL=10) -> sel_o stays 0, done_o with err_o=1 next cycle, inj_cnt_o unchanged.
REQ-034 delay=100, abort at cycle 50 -> no injection, done_o err_o=2 cycle 51, IDLE cycle 52.
REQ-035 rst_n pulled low mid-INJECT (len=8, cycle 3 of 8) -> sel_o=0 asynchronously, cfg_ready=1 after release, inj_cnt_o=0.
REQ-036 Preload count 16'hFFFE, two successful injections -> inj_cnt_o reads 16'hFFFF after both.
